// File: rtl/tt_um_cnt_stream_checker.sv
// -----------------------------------------------------------------------------
// tt_um_cnt_stream_checker
//
// Receive-side checker for the free-running 8-bit counter test source. Each
// clock the byte on uio_in is captured. One edge later it is compared against
// the previous captured byte plus one (mod 256).
// After LOCK_CNT consecutive matches the checker declares lock. While locked
// it counts good bytes and sequence errors. Both counters saturate.
//
// Ports
//   clk      clock
//   rst_n    asynchronous active-low reset
//   ena      unused
//   ui_in    [0]=en, [1]=clr, [3:2]=display select, [7:4] unused
//   uo_out   display byte:
//              sel0 = {lock_ev, state, err_flag, locked}
//              sel1 = err_cnt[7:0]
//              sel2 = good_cnt[7:0]
//              sel3 = good_cnt[15:8]
//   uio_in   byte stream under test
//   uio_out  tied low
//   uio_oe   tied low (all uio pins are inputs)
// -----------------------------------------------------------------------------
module tt_um_cnt_stream_checker #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8,
  parameter int GOOD_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEED    = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  localparam logic [3:0]        LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0]        ONE4     = 4'd1;
  localparam logic [3:0]        LOCK_MAX = 4'hF;
  localparam logic [ERR_W-1:0]  ERR_ONE  = 1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
  localparam logic [GOOD_W-1:0] GOOD_ONE = 1;
  localparam logic [GOOD_W-1:0] GOOD_MAX = '1;

  logic       en;
  logic       clr;
  logic [1:0] sel;
  assign en  = ui_in[0];
  assign clr = ui_in[1];
  assign sel = ui_in[3:2];

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, ui_in[7:4]};

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Internal reset: released one edge after rst_n rises. The core is held
  // clear until that edge, so it first runs on the edge after.
  logic rst_n_i_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_n_i_q <= 1'b0;
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    else        rst_n_i_q <= 1'b1;
  end

  state_e            state_q,    state_d;
  logic [7:0]        s_q,        s_d;
  logic [7:0]        exp_q,      exp_d;
  logic [3:0]        run_q,      run_d;
  logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [3:0]        lock_ev_q,  lock_ev_d;
  logic              err_flag_q, err_flag_d;

  logic hit;
  assign hit = (s_q == exp_q);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first; any path that
    // skips an assignment would otherwise infer a latch.
    state_d    = state_q;
    s_d        = uio_in;
    exp_d      = exp_q;
    run_d      = run_q;
    err_cnt_d  = err_cnt_q;
    good_cnt_d = good_cnt_q;
    lock_ev_d  = lock_ev_q;
    err_flag_d = err_flag_q;

    if (!en) begin
      // Dropping enable wins over any compare result in the same cycle.
      state_d = IDLE;
      run_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = SEED;
        SEED: begin
          exp_d   = s_q + 8'd1;
          run_d   = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          exp_d = s_q + 8'd1;
          if (hit) begin
            run_d = run_q + ONE4;
            if (run_q + ONE4 == LOCK_TGT) begin
              state_d = LOCKED;
              if (lock_ev_q != LOCK_MAX) lock_ev_d = lock_ev_q + ONE4;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          exp_d = s_q + 8'd1;
          if (hit) begin
            if (good_cnt_q != GOOD_MAX) good_cnt_d = good_cnt_q + GOOD_ONE;
          end else begin
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
            err_flag_d = 1'b1;
            run_d      = '0;
            state_d    = ACQUIRE;
          end
        end
      endcase
    end

    // Clear overrides any same-cycle increment; that event is lost.
    if (clr) begin
      err_cnt_d  = '0;
      good_cnt_d = '0;
      lock_ev_d  = '0;
      err_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= '0;
      exp_q      <= '0;
      run_q      <= '0;
      err_cnt_q  <= '0;
      good_cnt_q <= '0;
      lock_ev_q  <= '0;
      err_flag_q <= 1'b0;
    end else if (!rst_n_i_q) begin
      state_q    <= IDLE;
      s_q        <= '0;
      exp_q      <= '0;
      run_q      <= '0;
      err_cnt_q  <= '0;
      good_cnt_q <= '0;
      lock_ev_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      exp_q      <= exp_d;
      run_q      <= run_d;
      err_cnt_q  <= err_cnt_d;
      good_cnt_q <= good_cnt_d;
      lock_ev_q  <= lock_ev_d;
      err_flag_q <= err_flag_d;
    end
  end

  logic [7:0]  err_view;
  logic [15:0] good_view;
  assign err_view  = 8'(err_cnt_q);
  assign good_view = 16'(good_cnt_q);

  always_comb begin
    uo_out = 8'h00;
    if (rst_n_i_q) begin
      case (sel)
        2'd0:    uo_out = {lock_ev_q, state_q, err_flag_q, (state_q == LOCKED)};
        2'd1:    uo_out = err_view;
        2'd2:    uo_out = good_view[7:0];
        default: uo_out = good_view[15:8];
      endcase
    end
  end

endmodule
